instr_mem_loader: RTL and testbench

Program loader that writes 32-bit instructions into the writable instruction memory ahead of execution. It accepts a byte stream over a valid/ready handshake, packs each 4 bytes into one instruction word (MSB first, so the opcode nibble arrives in the first byte), and drives the memory write port at consecutive 8-bit addresses. It holds the CPU in reset while a load is in progress. It sits between the host/debug byte source and the instruction memory write port, opposite the fetch-side read port.

---
 rtl/instr_mem_loader.sv | 135 +++++++++++++
 tb/tb_instr_mem_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs 4 bytes MSB-first into a 32-bit instruction
// and writes it to consecutive instruction-memory addresses, holding the CPU meanwhile.
module instr_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        cks_q, cks_d;

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      cks_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cks_q   <= cks_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cks_d   = cks_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = start_addr;
          // counts above the memory depth are clamped to a full-memory load
          rem_d  = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          cks_d  = 8'd0;
          idx_d  = 2'd0;
          word_d = 32'd0;
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          case (idx_q)
            2'd0:    word_d[31:24] = in_data;
            2'd1:    word_d[23:16] = in_data;
            2'd2:    word_d[15:8]  = in_data;
            2'd3:    word_d[7:0]   = in_data;
            default: word_d        = word_q;
          endcase
          cks_d = cks_q ^ in_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_ONE;
        rem_d  = rem_q - REM_ONE;
        idx_d  = 2'd0;
        if (rem_q == REM_ONE) begin
          state_d = DONE;
        end else begin
          state_d = COLLECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers, so in_valid never reaches in_ready.
  assign in_ready = (state_q == COLLECT);
  assign wr_en    = (state_q == WRITE);
  assign wr_addr  = addr_q;
  assign wr_data  = word_q;
  assign busy     = (state_q != IDLE);
  assign cpu_hold = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign checksum = cks_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected writes and
// done/checksum events; a negedge monitor pops and compares them.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [7:0]  checksum;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] c; bit zero; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic prev_wr_en = 1'b0;
  logic prev_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    wq.push_back(e);
  endtask

  task automatic expect_done(input logic [7:0] c, input bit zero);
    dn_t e;
    e.c = c; e.zero = zero;
    dq.push_back(e);
  endtask

  // Monitor: compare every write and done pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_count++;
        check("in_ready_during_write", {31'd0, in_ready}, 32'd0);
        check("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
          check("wr_data", wr_data, e.d);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          dn_t e;
          e = dq.pop_front();
          check("checksum", {24'd0, checksum}, {24'd0, e.c});
          check("busy_at_done", {31'd0, busy}, 32'd1);
          if (!e.zero) check("done_after_write", {31'd0, prev_wr_en}, 32'd1);
        end
      end
      if (prev_done) check("busy_falls_after_done", {31'd0, busy}, 32'd0);
      prev_wr_en <= wr_en;
      prev_done  <= done;
    end else begin
      prev_wr_en <= 1'b0;
      prev_done  <= 1'b0;
    end
  end

  // All tasks below start and end just after a falling edge.
  task automatic pulse_start(input logic [7:0] a, input logic [8:0] n);
    start = 1'b1; start_addr = a; word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 200;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL byte_timeout: got in_ready=0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_finish();
    int budget = 5000;
    in_valid = 1'b0;
    while ((busy || dq.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL load_timeout: got busy=%0d expected 0", busy);
    end
    @(negedge clk);
    check("write_queue_drained", wq.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] bytes12 [12];
    logic [7:0] b;
    logic [7:0] cks;
    logic [31:0] w;
    int base;

    rst_n = 1'b0; start = 1'b0; start_addr = 8'd0; word_count = 9'd0;
    in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word, back-to-back bytes
    expect_write(8'h00, 32'h71041000);
    expect_done(8'h65, 1'b0);
    pulse_start(8'h00, 9'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h71); send_byte(8'h04); send_byte(8'h10); send_byte(8'h00);
    in_valid = 1'b0;
    check("write_cycle_in_ready", {31'd0, in_ready}, 32'd0);
    check("write_cycle_wr_en", {31'd0, wr_en}, 32'd1);
    wait_finish();
    check("checksum_stable", {24'd0, checksum}, 32'h65);

    // Address wrap 254,255,0
    bytes12 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h15, 8'h26, 8'h37, 8'h48,
                8'h9F, 8'h8E, 8'h7D, 8'h6C};
    expect_write(8'hFE, 32'hA1B2C3D4);
    expect_write(8'hFF, 32'h15263748);
    expect_write(8'h00, 32'h9F8E7D6C);
    expect_done(8'h48, 1'b0);
    pulse_start(8'hFE, 9'd3);
    for (int i = 0; i < 12; i++) send_byte(bytes12[i]);
    wait_finish();

    // Zero-length load
    expect_done(8'h00, 1'b1);
    pulse_start(8'h33, 9'd0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("zero_busy_one_cycle", {31'd0, busy}, 32'd0);
    wait_finish();

    // Eight words with random source gaps
    base = wr_count;
    cks = 8'd0;
    for (int wi = 0; wi < 8; wi++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(wi * 37 + k * 11 + 5);
        w = {w[23:0], b};
        cks = cks ^ b;
      end
      expect_write(8'(8'h20 + wi), w);
    end
    expect_done(cks, 1'b0);
    pulse_start(8'h20, 9'd8);
    for (int wi = 0; wi < 8; wi++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        send_byte(8'(wi * 37 + k * 11 + 5));
      end
    end
    wait_finish();
    check("eight_write_pulses", wr_count - base, 32'd8);

    // Start mid-load ignored; in_valid in IDLE ignored
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    expect_write(8'h50, 32'h01020304);
    expect_write(8'h51, 32'h05060708);
    expect_done(8'h08, 1'b0);
    pulse_start(8'h50, 9'd2);
    send_byte(8'h01); send_byte(8'h02);
    in_valid = 1'b0;
    pulse_start(8'h90, 9'd5);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    wait_finish();
    in_valid = 1'b1; in_data = 8'h99;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("no_load_after_idle_valid", {31'd0, busy}, 32'd0);

    // Asynchronous reset after 2 bytes of word 3
    expect_write(8'h10, 32'h11121314);
    expect_write(8'h11, 32'h15161718);
    pulse_start(8'h10, 9'd4);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h11 + i));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_wr_en", {31'd0, wr_en}, 32'd0);
    check("arst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("arst_wr_data", wr_data, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_checksum", {24'd0, checksum}, 32'd0);
    check("arst_writes_seen", wq.size(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_write(8'h40, 32'hC0FFEE01);
    expect_done(8'hD0, 1'b0);
    pulse_start(8'h40, 9'd1);
    send_byte(8'hC0); send_byte(8'hFF); send_byte(8'hEE); send_byte(8'h01);
    wait_finish();

    // Oversized count clamps to 256 words, wrapping the address
    base = wr_count;
    cks = 8'd0;
    for (int wi = 0; wi < 256; wi++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(wi + k * 64);
        w = {w[23:0], b};
        cks = cks ^ b;
      end
      expect_write(8'(8'h80 + wi), w);
    end
    expect_done(cks, 1'b0);
    pulse_start(8'h80, 9'd300);
    for (int wi = 0; wi < 256; wi++)
      for (int k = 0; k < 4; k++) send_byte(8'(wi + k * 64));
    wait_finish();
    check("clamp_write_pulses", wr_count - base, 32'd256);
    check("done_queue_drained", dq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
